// File: rtl/csa64_operand_loader_if.sv
// Word stream into the csa64 operand loader: the upstream source drives data/valid,
// and the loader returns ready.
interface csa64_operand_loader_if #(
  parameter int WORD_W = 16
);
  logic [WORD_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/csa64_operand_loader.sv
// Feeder for the 64-bit clocked carry-select adder: assembles op1/op2 from a word stream,
// waits out the adder latency, then captures sum and carry-out with a one-cycle valid pulse.
//
// state  | meaning
// LOAD_A | accepting op1 words, LS word first; ready high
// LOAD_B | accepting op2 words, LS word first; ready high
// WAIT   | operands stable, counting down adder latency; ready low
module csa64_operand_loader #(
  parameter int WORD_W  = 16,
  parameter int OP_W    = 64,
  parameter int ADD_LAT = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  csa64_operand_loader_if.slave   in_if,
  output logic [OP_W-1:0]         op1,
  output logic [OP_W-1:0]         op2,
  input  logic [OP_W-1:0]         add_sum,
  input  logic                    add_crout,
  output logic [OP_W-1:0]         res_sum,
  output logic                    res_crout,
  output logic                    res_valid,
  output logic                    busy
);

  localparam int NWORDS = OP_W / WORD_W;
  localparam int CNT_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam int LAT_W  = 4;

  localparam logic [1:0] LOAD_A = 2'd0;
  localparam logic [1:0] LOAD_B = 2'd1;
  localparam logic [1:0] WAIT   = 2'd2;

  logic [1:0]       state;
  logic [CNT_W-1:0] wcnt;
  logic [LAT_W-1:0] lcnt;
  logic             in_ready;
  logic             accept;
  logic             last_word;

  assign in_ready       = (state != WAIT);
  assign in_if.in_ready = in_ready;
  assign accept         = in_if.in_valid && in_ready;
  assign last_word      = (wcnt == CNT_W'(NWORDS - 1));
  assign busy           = (state == LOAD_B) || (state == WAIT) ||
                          ((state == LOAD_A) && (wcnt != '0));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= LOAD_A;
      wcnt      <= '0;
      lcnt      <= '0;
      op1       <= '0;
      op2       <= '0;
      res_sum   <= '0;
      res_crout <= 1'b0;
      res_valid <= 1'b0;
    end else begin
      res_valid <= 1'b0;
      case (state)
        LOAD_A: begin
          if (accept) begin
            for (int k = 0; k < NWORDS; k++) begin
              if (wcnt == CNT_W'(k)) op1[k*WORD_W +: WORD_W] <= in_if.in_data;
            end
            if (last_word) begin
              wcnt  <= '0;
              state <= LOAD_B;
            end else begin
              wcnt <= wcnt + CNT_W'(1);
            end
          end
        end
        LOAD_B: begin
          if (accept) begin
            for (int k = 0; k < NWORDS; k++) begin
              if (wcnt == CNT_W'(k)) op2[k*WORD_W +: WORD_W] <= in_if.in_data;
            end
            if (last_word) begin
              wcnt  <= '0;
              // Terminal count 0 lands the capture exactly ADD_LAT edges after this one.
              lcnt  <= LAT_W'(ADD_LAT - 1);
              state <= WAIT;
            end else begin
              wcnt <= wcnt + CNT_W'(1);
            end
          end
        end
        WAIT: begin
          if (lcnt != '0) begin
            lcnt <= lcnt - LAT_W'(1);
          end else begin
            res_sum   <= add_sum;
            res_crout <= add_crout;
            res_valid <= 1'b1;
            state     <= LOAD_A;
          end
        end
        default: begin
          state <= LOAD_A;
          wcnt  <= '0;
          lcnt  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_csa64_operand_loader.sv
// Scoreboard bench for csa64_operand_loader: randomized word streams against a plain-arithmetic
// reference, plus ADD_LAT=1 and ADD_LAT=4 instances checked for capture timing.
module tb_csa64_operand_loader;
  localparam int L = 2;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  csa64_operand_loader_if #(.WORD_W(16)) ifm ();
  csa64_operand_loader_if #(.WORD_W(16)) ifl1 ();
  csa64_operand_loader_if #(.WORD_W(16)) ifl4 ();

  logic [63:0] op1, op2, res_sum;
  logic [63:0] add_sum = '0;
  logic        add_crout = 1'b0;
  logic        res_crout, res_valid, busy;

  logic [63:0] l1_op1, l1_op2, l1_add_sum, l1_res_sum;
  logic        l1_add_crout, l1_res_crout, l1_res_valid, l1_busy;
  logic [63:0] l4_op1, l4_op2, l4_add_sum, l4_res_sum;
  logic        l4_add_crout, l4_res_crout, l4_res_valid, l4_busy;

  csa64_operand_loader #(.WORD_W(16), .OP_W(64), .ADD_LAT(L)) dut (
    .clock(clock), .reset(reset), .in_if(ifm), .op1(op1), .op2(op2),
    .add_sum(add_sum), .add_crout(add_crout), .res_sum(res_sum),
    .res_crout(res_crout), .res_valid(res_valid), .busy(busy));

  csa64_operand_loader #(.WORD_W(16), .OP_W(64), .ADD_LAT(1)) dut_l1 (
    .clock(clock), .reset(reset), .in_if(ifl1), .op1(l1_op1), .op2(l1_op2),
    .add_sum(l1_add_sum), .add_crout(l1_add_crout), .res_sum(l1_res_sum),
    .res_crout(l1_res_crout), .res_valid(l1_res_valid), .busy(l1_busy));

  csa64_operand_loader #(.WORD_W(16), .OP_W(64), .ADD_LAT(4)) dut_l4 (
    .clock(clock), .reset(reset), .in_if(ifl4), .op1(l4_op1), .op2(l4_op2),
    .add_sum(l4_add_sum), .add_crout(l4_add_crout), .res_sum(l4_res_sum),
    .res_crout(l4_res_crout), .res_valid(l4_res_valid), .busy(l4_busy));

  // Registered adder for the main instance (one register stage, total latency 2).
  always @(posedge clock) {add_crout, add_sum} <= {1'b0, op1} + {1'b0, op2};
  assign {l1_add_crout, l1_add_sum} = {1'b0, l1_op1} + {1'b0, l1_op2};
  assign {l4_add_crout, l4_add_sum} = {1'b0, l4_op1} + {1'b0, l4_op2};

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [64:0] got, input logic [64:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic logic [64:0] ref_add(input logic [63:0] a, input logic [63:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  typedef struct {
    logic [63:0] sum;
    logic        cr;
    int          edge_n;
  } exp_t;
  exp_t sb[$];

  logic [63:0] last_sum = '0;
  logic        last_cr = 1'b0;

  // Monitor: pops the scoreboard on every res_valid; otherwise results must hold.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      #1;
      if (!reset) begin
        last_sum = '0;
        last_cr  = 1'b0;
      end else if (res_valid) begin
        if (sb.size() == 0) begin
          check("res_valid with empty scoreboard", 65'(res_valid), 65'(0));
        end else begin
          e = sb.pop_front();
          check("res_sum", 65'(res_sum), 65'(e.sum));
          check("res_crout", 65'(res_crout), 65'(e.cr));
          check("capture edge", 65'(cyc), 65'(e.edge_n));
          last_sum = e.sum;
          last_cr  = e.cr;
        end
      end else begin
        check("result hold", {res_crout, res_sum}, {last_cr, last_sum});
      end
    end
  end

  task automatic send_word(input logic [15:0] w, input int gap, output bit rv_at_acc);
    int tries;
    rv_at_acc = 1'b0;
    repeat (gap) begin
      @(negedge clock);
      ifm.in_valid = 1'b0;
      ifm.in_data  = 16'($urandom);
    end
    tries = 0;
    forever begin
      @(negedge clock);
      ifm.in_valid = 1'b1;
      ifm.in_data  = w;
      if (ifm.in_ready) break;
      tries++;
      if (tries > 50) begin
        n_checks++;
        n_fail++;
        $display("FAIL word accept timeout: in_ready stayed %b, required 1", ifm.in_ready);
        return;
      end
    end
    rv_at_acc = res_valid;
    @(posedge clock);
  endtask

  task automatic send_txn(input logic [63:0] a, input logic [63:0] b, input int gapmax,
                          input bit hold, input bit first_done, input bit chain,
                          input logic [15:0] next_w0);
    bit rv;
    int e0, cnt;
    logic [15:0] w;
    logic [64:0] r;
    for (int k = 0; k < 8; k++) begin
      if (!(k == 0 && first_done)) begin
        w = (k < 4) ? a[16*k +: 16] : b[16*(k-4) +: 16];
        send_word(w, int'($urandom_range(0, gapmax)), rv);
      end
    end
    @(negedge clock);
    ifm.in_valid = hold;
    ifm.in_data  = 16'($urandom);
    #1;
    e0 = cyc;
    check("op1 at E0", 65'(op1), 65'(a));
    check("op2 at E0", 65'(op2), 65'(b));
    check("busy in WAIT", 65'(busy), 65'(1));
    r = ref_add(a, b);
    sb.push_back('{sum: r[63:0], cr: r[64], edge_n: e0 + L});
    cnt = 0;
    while (!ifm.in_ready && cnt < 20) begin
      cnt++;
      @(negedge clock);
      ifm.in_valid = hold;
      ifm.in_data  = 16'($urandom);
      #1;
    end
    check("in_ready low cycles", 65'(cnt), 65'(L));
    if (chain) begin
      ifm.in_valid = 1'b1;
      ifm.in_data  = next_w0;
      rv = res_valid;
      check("b2b word0 in res_valid cycle", 65'(rv), 65'(1));
      @(posedge clock);
    end else begin
      ifm.in_valid = 1'b0;
    end
  endtask

  task automatic lat_test(input logic [63:0] a, input logic [63:0] b);
    logic [15:0] w;
    logic [64:0] r;
    r = ref_add(a, b);
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      w = (k < 4) ? a[16*k +: 16] : b[16*(k-4) +: 16];
      ifl1.in_valid = 1'b1; ifl1.in_data = w;
      ifl4.in_valid = 1'b1; ifl4.in_data = w;
    end
    @(negedge clock);
    ifl1.in_valid = 1'b0;
    ifl4.in_valid = 1'b0;
    #1;
    check("lat1 busy at E0", 65'(l1_busy), 65'(1));
    check("lat4 busy at E0", 65'(l4_busy), 65'(1));
    for (int k = 1; k <= 6; k++) begin
      @(negedge clock);
      #1;
      check("lat1 res_valid", 65'(l1_res_valid), 65'(k == 1));
      check("lat4 res_valid", 65'(l4_res_valid), 65'(k == 4));
      check("lat1 busy", 65'(l1_busy), 65'(0));
      check("lat4 busy", 65'(l4_busy), 65'(k < 4));
      if (k == 1) check("lat1 result", {l1_res_crout, l1_res_sum}, r);
      if (k == 4) check("lat4 result", {l4_res_crout, l4_res_sum}, r);
    end
  endtask

  initial begin
    bit rv;
    int t;
    logic [63:0] a, b, a2, b2;
    ifm.in_valid  = 1'b0; ifm.in_data  = '0;
    ifl1.in_valid = 1'b0; ifl1.in_data = '0;
    ifl4.in_valid = 1'b0; ifl4.in_data = '0;

    reset = 1'b0;
    repeat (3) @(negedge clock);
    #1;
    check("reset op1", 65'(op1), 65'(0));
    check("reset op2", 65'(op2), 65'(0));
    check("reset res", {res_crout, res_sum}, 65'(0));
    check("reset res_valid", 65'(res_valid), 65'(0));
    check("reset busy", 65'(busy), 65'(0));
    check("reset in_ready", 65'(ifm.in_ready), 65'(1));
    reset = 1'b1;

    send_txn(64'h1234_ffff_dfff_eeee, 64'hdddd_dddd_dddd_dddd, 0, 1'b0, 1'b0, 1'b0, 16'h0);
    send_txn(64'hffff_ffff_ffff_ffff, 64'h0000_0000_0000_0001, 0, 1'b1, 1'b0, 1'b0, 16'h0);
    send_txn(64'h1234_ffff_dfff_eeee, 64'hdddd_dddd_dddd_dddd, 3, 1'b1, 1'b0, 1'b0, 16'h0);

    for (int i = 0; i < 6; i++) begin
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      send_txn(a, b, 3, 1'($urandom_range(0, 1)), 1'b0, 1'b0, 16'h0);
    end

    a  = {$urandom, $urandom};
    b  = {$urandom, $urandom};
    a2 = {$urandom, $urandom};
    b2 = {$urandom, $urandom};
    send_txn(a, b, 0, 1'b0, 1'b0, 1'b1, a2[15:0]);
    send_txn(a2, b2, 0, 1'b0, 1'b1, 1'b0, 16'h0);

    // Reset in the middle of op2 loading.
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    for (int k = 0; k < 6; k++) begin
      send_word((k < 4) ? a[16*k +: 16] : b[16*(k-4) +: 16], 0, rv);
    end
    @(negedge clock);
    ifm.in_valid = 1'b0;
    reset = 1'b0;
    #1;
    check("mid reset op1", 65'(op1), 65'(0));
    check("mid reset op2", 65'(op2), 65'(0));
    check("mid reset res_valid", 65'(res_valid), 65'(0));
    check("mid reset busy", 65'(busy), 65'(0));
    check("mid reset in_ready", 65'(ifm.in_ready), 65'(1));
    @(negedge clock);
    reset = 1'b1;
    send_txn(64'd1, 64'd2, 1, 1'b0, 1'b0, 1'b0, 16'h0);

    lat_test({$urandom, $urandom}, {$urandom, $urandom});

    t = 0;
    while (sb.size() != 0 && t < 50) begin
      @(negedge clock);
      t++;
    end
    check("scoreboard drained", 65'(sb.size()), 65'(0));
    repeat (3) @(negedge clock);
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/csa64_operand_loader.md
Name: csa64_operand_loader

Overview:
Upstream feeder stage for the 64-bit clocked carry-select adder. Accepts operands as 16-bit words over a valid/ready stream and assembles them into op1 and op2. Drives the adder's op1/op2 inputs directly, waits a fixed adder latency, then captures the adder's sum and carry-out into result registers with a one-cycle valid pulse. The FSM sequences load A, load B, wait and capture, and supports back-to-back transactions.

Parameters:
WORD_W, 16, input word width; OP_W must be a multiple of WORD_W.
OP_W, 64, operand/sum width; NWORDS = OP_W/WORD_W = 4.
ADD_LAT, 2, clock edges from final operand word accepted to sum capture; legal range 1..15.

Ports:
clock  in  1  single clock, rising edge.
reset  in  1  asynchronous, active-low reset (0 = reset).
in_data  in  WORD_W  operand word, least-significant word first.
in_valid  in  1  in_data valid.
in_ready  out  1  loader accepts a word this cycle.
op1  out  OP_W  operand A to adder.
op2  out  OP_W  operand B to adder.
add_sum  in  OP_W  adder sum output.
add_crout  in  1  adder carry-out.
res_sum  out  OP_W  captured sum.
res_crout  out  1  captured carry-out.
res_valid  out  1  one-cycle pulse: res_sum/res_crout updated.
busy  out  1  transaction in progress.

Behaviour:
- Reset (reset=0, asynchronous): state=LOAD_A, word count=0, latency count=0, op1=op2=0, res_sum=0, res_crout=0, res_valid=0. in_ready=1 after reset deasserts. Reset mid-transaction discards partial operands and clears them.
- Word accept: in_valid && in_ready at a rising edge. If in_valid is asserted while in_ready=0, the word is ignored, not queued. Gaps in in_valid are allowed, and the count holds across them.
- LOAD_A (in_ready=1): accepted word k (k=0..3) writes op1[16k+15:16k]. Other op1 bits hold. After word 3 is accepted, count returns to 0 and the FSM goes to LOAD_B.
- LOAD_B (in_ready=1): same word mapping into op2. When word 3 is accepted (edge E0), latency count is loaded with ADD_LAT-1 and the FSM goes to WAIT.
- WAIT (in_ready=0): at each edge, if count≠0 it decrements. At the edge where count==0 (edge E0+ADD_LAT):
  - res_sum <= add_sum and res_crout <= add_crout;
  - res_valid <= 1 for exactly one cycle;
  - FSM goes to LOAD_A.
- Timing: op1/op2 are stable from E0 through the capture edge. With ADD_LAT=2, the registered adder samples at E0+1 and is captured at E0+2.
- op1/op2 hold after capture until overwritten word-by-word by the next transaction. res_sum/res_crout hold until the next capture.
- Back-to-back: in_ready=1 in the cycle res_valid=1, so a new word 0 may be accepted in that cycle.
- busy=1 in LOAD_B, in WAIT, and in LOAD_A with count≠0. busy=0 otherwise.
- All outputs are registered except in_ready and busy, which are decoded combinationally from state/count.
- No arithmetic in this block. Widths are exact; no truncation or extension.

Test Plan:
- Reset then stream words eeee, dfff, ffff, 1234 (op1) and dddd ×4 (op2), with the adder (or a model with the same latency) attached -> op1=1234_ffff_dfff_eeee and op2=dddd_dddd_dddd_dddd at E0; res_valid pulses exactly at E0+2 with res_sum=f012_dddd_bddd_cccb and res_crout=0.
- op1=ffff_ffff_ffff_ffff, op2=0000_0000_0000_0001 -> res_sum=0, res_crout=1, single-cycle res_valid.
- Random 1–3 cycle in_valid gaps between words, plus in_valid held high throughout WAIT -> same result as the gap-free run; no extra words absorbed; in_ready=0 for exactly ADD_LAT cycles.
- Assert reset=0 for one cycle after two words of op2 -> op1=op2=0, res_valid=0, state LOAD_A. A following full transaction 1+2 gives res_sum=3, res_crout=0.
- Back-to-back: present word 0 of transaction 2 during the res_valid cycle of transaction 1 -> word accepted; transaction 2 result appears NWORDS×2+ADD_LAT-1 edges later; transaction 1 result holds until then.
- ADD_LAT=1 build -> capture at E0+1; ADD_LAT=4 build -> capture at E0+4; busy deasserts the cycle after capture.
